// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode and FSM state definitions for the sequential ALU.
//   OP_*     : 3-bit opcodes accepted on aluop_i
//   state_e  : 2-bit FSM state (StIdle / StMul / StDiv)
//   is_iter_op: true for opcodes that use the iterative multiply/divide unit
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10
  } state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier and restoring
// divider sharing a single 2*WIDTH accumulator.
//   clk_i, rst_n_i : clock, async active-low reset
//   start_i        : load operands and begin WIDTH iterations
//   is_div_i       : 1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i       : multiplicand/dividend, multiplier/divisor
//   done_o         : the current cycle performs the final iteration
//   lo_o, hi_o     : accumulator value after the current iteration
//                    (product low/high or quotient/remainder when done_o)
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CNTW-1:0]    r_cnt;
  logic               r_div;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}; add b into
    // the upper half when the multiplier LSB is set, then shift right.
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};
    // Divide: acc = {remainder, dividend/quotient bits}; shift left, try to
    // subtract b, and keep the difference only if it did not borrow. A zero
    // divisor never borrows, which yields quotient all-ones and remainder A.
    w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_rem_sh - {1'b0, r_b};
    if (w_diff[WIDTH]) begin
      w_div_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
    w_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (start_i) begin
      r_acc <= {{WIDTH{1'b0}}, a_i};
      r_b   <= b_i;
      r_cnt <= CNTW'(WIDTH);
      r_div <= is_div_i;
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  // Results are exposed combinationally so the owner can register them on the
  // same edge the last iteration completes.
  assign done_o = (r_cnt == CNTW'(1));
  assign lo_o   = w_acc_nxt[WIDTH-1:0];
  assign hi_o   = w_acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready operand handshake. Single-cycle
// ADD/SUB/OR/AND/SLT/reserved; iterative MULU/DIVU (WIDTH cycles) via
// alu_muldiv_iter.
//   clk_i, rst_n_i    : clock, async active-low reset
//   valid_i, ready_o  : operand handshake (ready only in idle)
//   aluop_i, src0_i/1 : opcode and operands, sampled on accept
//   valid_o           : one-cycle pulse marking new results
//   aluout_o, hi_o    : primary result, product high / remainder
//   zero_o            : aluout_o == 0
//   overflow_o        : signed ADD/SUB overflow when ALU_SEQ_OVERFLOW_EN is
//                       defined, otherwise constant 0
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       aluop_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] aluout_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  state_e           r_state, w_state_d;
  logic             r_valid, w_valid_d;
  logic [WIDTH-1:0] r_aluout, w_aluout_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic             r_zero, w_zero_d;

  logic             w_sc_done;
  logic             w_md_done;
  logic             w_start;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_hi;

  assign ready_o = (r_state == StIdle);
  assign w_start = valid_i && ready_o && is_iter_op(aluop_i);

  // Single-cycle results.
  always_comb begin
    w_sum  = src0_i + src1_i;
    w_diff = src0_i - src1_i;
    case (aluop_i)
      OP_ADD:  w_sc_res = w_sum;
      OP_SUB:  w_sc_res = w_diff;
      OP_OR:   w_sc_res = src0_i | src1_i;
      OP_AND:  w_sc_res = src0_i & src1_i;
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(src0_i) < $signed(src1_i))};
      default: w_sc_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (w_start),
    .is_div_i (aluop_i == OP_DIVU),
    .a_i      (src0_i),
    .b_i      (src1_i),
    .done_o   (w_iter_done),
    .lo_o     (w_iter_lo),
    .hi_o     (w_iter_hi)
  );

  // FSM next state and completion strobes.
  always_comb begin
    w_state_d = r_state;
    w_sc_done = 1'b0;
    w_md_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (valid_i) begin
          if (aluop_i == OP_MULU) begin
            w_state_d = StMul;
          end else if (aluop_i == OP_DIVU) begin
            w_state_d = StDiv;
          end else begin
            w_sc_done = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        if (w_iter_done) begin
          w_state_d = StIdle;
          w_md_done = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output registers hold until the next completion.
  always_comb begin
    w_valid_d  = w_sc_done || w_md_done;
    w_aluout_d = r_aluout;
    w_hi_d     = r_hi;
    w_zero_d   = r_zero;
    if (w_sc_done) begin
      w_aluout_d = w_sc_res;
      w_hi_d     = '0;
      w_zero_d   = (w_sc_res == '0);
    end else if (w_md_done) begin
      w_aluout_d = w_iter_lo;
      w_hi_d     = w_iter_hi;
      w_zero_d   = (w_iter_lo == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= StIdle;
      r_valid  <= 1'b0;
      r_aluout <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_valid  <= w_valid_d;
      r_aluout <= w_aluout_d;
      r_hi     <= w_hi_d;
      r_zero   <= w_zero_d;
    end
  end

  assign valid_o  = r_valid;
  assign aluout_o = r_aluout;
  assign hi_o     = r_hi;
  assign zero_o   = r_zero;

`ifdef ALU_SEQ_OVERFLOW_EN
  logic r_ovf, w_ovf_d, w_ovf_sc;

  always_comb begin
    w_ovf_sc = 1'b0;
    if (aluop_i == OP_ADD) begin
      w_ovf_sc = (src0_i[WIDTH-1] == src1_i[WIDTH-1]) && (w_sum[WIDTH-1] != src0_i[WIDTH-1]);
    end else if (aluop_i == OP_SUB) begin
      w_ovf_sc = (src0_i[WIDTH-1] != src1_i[WIDTH-1]) && (w_diff[WIDTH-1] != src0_i[WIDTH-1]);
    end
    w_ovf_d = r_ovf;
    if (w_sc_done) begin
      w_ovf_d = w_ovf_sc;
    end else if (w_md_done) begin
      w_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_d;
    end
  end

  assign overflow_o = r_ovf;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 32-bit instance
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  aluop_i = '0;
  logic [31:0] src0_i = '0;
  logic [31:0] src1_i = '0;
  logic        valid_o;
  logic [31:0] aluout_o;
  logic [31:0] hi_o;
  logic        zero_o;
  logic        overflow_o;

  // 8-bit instance
  logic        v8_valid_i = 1'b0;
  logic        v8_ready_o;
  logic [2:0]  v8_aluop_i = '0;
  logic [7:0]  v8_src0_i = '0;
  logic [7:0]  v8_src1_i = '0;
  logic        v8_valid_o;
  logic [7:0]  v8_aluout_o;
  logic [7:0]  v8_hi_o;
  logic        v8_zero_o;
  logic        v8_overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .aluop_i    (aluop_i),
    .src0_i     (src0_i),
    .src1_i     (src1_i),
    .valid_o    (valid_o),
    .aluout_o   (aluout_o),
    .hi_o       (hi_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .valid_i    (v8_valid_i),
    .ready_o    (v8_ready_o),
    .aluop_i    (v8_aluop_i),
    .src0_i     (v8_src0_i),
    .src1_i     (v8_src1_i),
    .valid_o    (v8_valid_o),
    .aluout_o   (v8_aluout_o),
    .hi_o       (v8_hi_o),
    .zero_o     (v8_zero_o),
    .overflow_o (v8_overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: arithmetic on the mathematical values of the operands.
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 output longint unsigned lo, output longint unsigned hi,
                                 output bit ovf);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint sa, sb, r, smax, smin;
    longint unsigned p;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sa = (a > longint'(smax)) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (b > longint'(smax)) ? longint'(b) - (longint'(1) << w) : longint'(b);
    lo = 0; hi = 0; ovf = 0;
    case (op)
      3'd0: begin lo = (a + b) & m; r = sa + sb; ovf = (r > smax) || (r < smin); end
      3'd1: begin lo = (a - b) & m; r = sa - sb; ovf = (r > smax) || (r < smin); end
      3'd2: lo = a | b;
      3'd3: lo = a & b;
      3'd4: lo = (sa < sb) ? 1 : 0;
      3'd5: begin p = a * b; lo = p & m; hi = (p >> w) & m; end
      3'd6: begin
        if (b == 0) begin lo = m; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
`ifndef ALU_SEQ_OVERFLOW_EN
    ovf = 0;
`endif
  endfunction

  // Called #1 after a rising edge with the 32-bit DUT idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned elo, ehi;
    bit eovf;
    int lat;
    ref_op(32, op, a, b, elo, ehi, eovf);
    chk("ready_idle", ready_o, 1);
    valid_i = 1'b1; aluop_i = op; src0_i = a; src1_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (op == 3'd5 || op == 3'd6) begin
      chk("ready_busy", ready_o, 0);
      lat = 0;
      // Junk requests while busy must be ignored.
      while (!valid_o && lat < 100) begin
        valid_i = 1'($urandom_range(0, 1));
        aluop_i = 3'($urandom); src0_i = $urandom; src1_i = $urandom;
        @(posedge clk); #1;
        lat++;
      end
      valid_i = 1'b0;
      chk("latency_edges", lat, 32);
    end
    chk("valid", valid_o, 1);
    chk("aluout", aluout_o, elo);
    chk("hi", hi_o, ehi);
    chk("zero", zero_o, (elo == 0));
    chk("overflow", overflow_o, eovf);
    chk("ready_after", ready_o, 1);
    @(posedge clk); #1;
    chk("valid_pulse", valid_o, 0);
    chk("aluout_hold", aluout_o, elo);
  endtask

  task automatic run_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    longint unsigned elo, ehi;
    bit eovf;
    int lat;
    ref_op(8, op, a, b, elo, ehi, eovf);
    v8_valid_i = 1'b1; v8_aluop_i = op; v8_src0_i = a; v8_src1_i = b;
    @(posedge clk); #1;
    v8_valid_i = 1'b0;
    lat = 0;
    if (op == 3'd5 || op == 3'd6) begin
      while (!v8_valid_o && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w8_latency_edges", lat, 8);
    end
    chk("w8_valid", v8_valid_o, 1);
    chk("w8_aluout", v8_aluout_o, elo);
    chk("w8_hi", v8_hi_o, ehi);
    chk("w8_zero", v8_zero_o, (elo == 0));
    chk("w8_overflow", v8_overflow_o, eovf);
    @(posedge clk); #1;
    chk("w8_valid_pulse", v8_valid_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    bit          seen;

    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_aluout", aluout_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_zero", zero_o, 1);
    chk("rst_overflow", overflow_o, 0);

    // Directed cases
    run_op(3'd0, 32'h7FFF_FFFF, 32'h1);

    // Back-to-back SUB then SLT
    valid_i = 1'b1; aluop_i = 3'd1; src0_i = 32'd5; src1_i = 32'd5;
    @(posedge clk); #1;
    chk("b2b_sub_valid", valid_o, 1);
    chk("b2b_sub_out", aluout_o, 0);
    chk("b2b_sub_zero", zero_o, 1);
    chk("b2b_ready", ready_o, 1);
    aluop_i = 3'd4; src0_i = 32'hFFFF_FFFF; src1_i = 32'h0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("b2b_slt_valid", valid_o, 1);
    chk("b2b_slt_out", aluout_o, 1);
    chk("b2b_slt_zero", zero_o, 0);
    @(posedge clk); #1;
    chk("b2b_valid_drop", valid_o, 0);

    run_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd100, 32'd7);
    run_op(3'd6, 32'd9, 32'd0);
    run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(3'd1, 32'h8000_0000, 32'h1);

    // Randomized ops, with some operands biased toward edge values
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: ra = 32'h7FFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = ra;
        default: ;
      endcase
      run_op(rop, ra, rb);
    end

    // Reset in the middle of a divide
    valid_i = 1'b1; aluop_i = 3'd6; src0_i = 32'd1000; src1_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_aluout", aluout_o, 0);
    chk("midrst_hi", hi_o, 0);
    chk("midrst_zero", zero_o, 1);
    chk("midrst_overflow", overflow_o, 0);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1;
    end
    chk("midrst_no_valid", seen, 0);
    run_op(3'd0, 32'd2, 32'd3);

    // WIDTH=8 instance
    run_op8(3'd5, 8'hFF, 8'h02);
    run_op8(3'd6, 8'd200, 8'd9);
    run_op8(3'd6, 8'd9, 8'd0);
    run_op8(3'd0, 8'h7F, 8'h01);
    for (int i = 0; i < 8; i++) begin
      run_op8(3'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the datapath single-cycle ALU. It adds AND, signed SLT, and iterative unsigned multiply and divide.
- Operands are accepted with a valid/ready handshake.
- The result is returned with a one-cycle valid_o pulse.
- Sits in the multi-cycle datapath between the register-read stage and the writeback mux. The HI/LO-style second result is driven on hi_o.

Parameters:
WIDTH, 32, operand/result width in bits (min 4).
CNTW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
valid_i  in  1  operation request
ready_o  out  1  block can accept an operation this cycle
aluop_i  in  3  opcode, sampled on accept
src0_i  in  WIDTH  operand A, sampled on accept
src1_i  in  WIDTH  operand B, sampled on accept
valid_o  out  1  one-cycle pulse: aluout_o/hi_o/zero_o/overflow_o are new
aluout_o  out  WIDTH  primary result (sum, diff, logic, slt, product low, quotient)
hi_o  out  WIDTH  product high / remainder; 0 for single-cycle ops
zero_o  out  1  aluout_o == 0, registered with aluout_o
overflow_o  out  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, clk_i. rst_n_i is asynchronous and active-low; release is synchronised externally.
- Reset values:
  - ready_o=1 (state IDLE)
  - valid_o=0, aluout_o=0, hi_o=0, overflow_o=0
  - zero_o=1 (consistent with aluout_o=0)
- Accept: the operation is accepted when valid_i && ready_o at a rising edge. ready_o = (state==IDLE), combinational from the state register only.
- Opcodes:
  - 000 ADD: A+B mod 2^WIDTH
  - 001 SUB: A-B mod 2^WIDTH
  - 010 OR
  - 011 AND
  - 100 SLT: signed A<B -> 1, else 0 (zero-extended)
  - 101 MULU: unsigned product, 2*WIDTH bits; low half on aluout_o, high half on hi_o
  - 110 DIVU: unsigned quotient on aluout_o, remainder on hi_o
  - 111 reserved: aluout_o=0, hi_o=0, single-cycle
- Single-cycle ops (000-100, 111), accepted at edge N:
  - results registered at edge N, valid_o=1 during cycle N..N+1
  - state stays IDLE, so back-to-back accepts every cycle are allowed.
- MULU: shift-add, one bit per cycle.
  - IDLE -> MUL on accept; counter loaded with WIDTH.
  - MUL -> IDLE when the counter reaches 0.
  - Results and valid_o are registered on that edge: accept at edge N, valid_o high in the cycle after edge N+WIDTH.
- DIVU: restoring division, one bit per cycle, same timing as MULU (IDLE -> DIV -> IDLE).
- Divide by zero: aluout_o = all ones, hi_o = A. No exception, same latency as a normal divide.
- While in MUL/DIV:
  - ready_o=0; valid_i is ignored and not queued.
  - operands were captured at accept, so input changes have no effect.
- Output hold: aluout_o, hi_o, zero_o and overflow_o hold their last values until the next completion. valid_o is high for exactly one cycle per accepted op. There is no output backpressure; the consumer must take the result on the pulse.
- Reset mid-operation: asserting rst_n_i at any time forces IDLE immediately. The in-flight result is discarded and no valid_o is produced.

Optional Feature:
Macro ALU_SEQ_OVERFLOW_EN.
- Defined: overflow_o is registered with results.
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when the operands' signs differ and the result sign differs from A.
  - All other ops: 0.
- Undefined: overflow_o is tied to 0 and no overflow logic is generated. The port is always present, so instantiations are identical in both builds.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_ADD..OP_RSVD (3-bit)
  - state encoding IDLE/MUL/DIV (2-bit)
- Sub-module alu_muldiv_iter, shared between multiply and divide:
  - holds the iterative shift datapath (2*WIDTH accumulator, operand register, counter)
  - interface: start, is_div, a, b, done, lo, hi
- The top keeps the FSM, the single-cycle ops and the output registers.

Test Plan:
- Reset, then ADD A=32'h7FFFFFFF B=1 -> next cycle valid_o=1, aluout_o=32'h80000000, zero_o=0, overflow_o=1 (macro on) / 0 (macro off).
- Back-to-back SUB 5-5, then SLT A=32'hFFFFFFFF B=0, on consecutive cycles -> two consecutive valid_o pulses; aluout_o=0 with zero_o=1, then aluout_o=1.
- MULU A=32'hFFFFFFFF B=32'hFFFFFFFF:
  - ready_o=0 for 32 cycles; valid_i pulses during that window are ignored.
  - valid_o arrives 33 cycles after accept with hi_o=32'hFFFFFFFE, aluout_o=32'h00000001.
- DIVU 100/7 -> aluout_o=14, hi_o=2. DIVU 9/0 -> aluout_o=32'hFFFFFFFF, hi_o=9, same latency.
- Assert rst_n_i mid-DIVU (cycle 10) -> outputs at reset values and ready_o=1 immediately; no valid_o afterwards. A new ADD 2+3 then yields 5.
- WIDTH=8 build: MULU 8'hFF*8'h02 -> hi_o=8'h01, aluout_o=8'hFE; valid_o arrives 9 cycles after accept.
